// File: rtl/aes_round_sequencer.sv
// Round-sequencing controller for the iterative AES datapath.
// Supports encrypt/decrypt per block, AES-128/192/256 round counts and
// ready/valid handshakes on both sides. Drives per-stage register enables
// and the round-key index for a shared round datapath and key schedule.
module aes_round_sequencer #(
  parameter int unsigned NR = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       mode,
  input  logic       abort,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       mode_q,
  output logic [3:0] round,
  output logic [3:0] key_idx,
  output logic       is_last,
  output logic       en_init,
  output logic       en_sub,
  output logic       en_row,
  output logic       en_col,
  output logic       en_key,
  output logic       en_dout
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : gen_bad_nr
    $error("aes_round_sequencer: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NrL = 4'(NR);

  typedef enum logic [2:0] {
    StIdle, StInit, StP1, StP2, StP3, StP4, StDout, StHold
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       mode_d;

  assign round   = round_q;
  assign is_last = (round_q == NrL);
  // Decrypt walks the key schedule backwards: INIT uses key NR, round r uses NR-r.
  assign key_idx = mode_q ? (NrL - round_q) : round_q;

  // State, round counter and latched mode registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      round_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic; abort overrides everything, including an accept.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    mode_d  = mode_q;
    if (abort) begin
      state_d = StIdle;
      round_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_d = StInit;
            round_d = '0;
            mode_d  = mode;
          end
        end
        StInit: begin
          state_d = StP1;
          round_d = 4'd1;
        end
        StP1: state_d = StP2;
        // Encrypt's final round has no MixColumns.
        StP2: state_d = (!mode_q && is_last) ? StP4 : StP3;
        // Decrypt's final round has no InvMixColumns.
        StP3: state_d = (mode_q && is_last) ? StDout : StP4;
        StP4: begin
          if (!mode_q && is_last) begin
            state_d = StDout;
          end else begin
            state_d = StP1;
            round_d = round_q + 4'd1;
          end
        end
        StDout: state_d = StHold;
        StHold: begin
          if (out_ready) begin
            if (in_valid) begin
              state_d = StInit;
              round_d = '0;
              mode_d  = mode;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Handshake, status and datapath enables; enables are suppressed in an abort cycle.
  always_comb begin
    in_ready  = (state_q == StIdle) || ((state_q == StHold) && out_ready);
    out_valid = (state_q == StHold);
    busy      = (state_q != StIdle) && (state_q != StHold);
    en_init   = 1'b0;
    en_sub    = 1'b0;
    en_row    = 1'b0;
    en_col    = 1'b0;
    en_key    = 1'b0;
    en_dout   = 1'b0;
    if (!abort) begin
      unique case (state_q)
        StInit: begin
          en_init = 1'b1;
          en_key  = 1'b1;
        end
        StP1: begin
          if (mode_q) en_row = 1'b1;
          else        en_sub = 1'b1;
        end
        StP2: begin
          if (mode_q) en_sub = 1'b1;
          else        en_row = 1'b1;
        end
        StP3: begin
          if (mode_q) en_key = 1'b1;
          else        en_col = 1'b1;
        end
        StP4: begin
          if (mode_q) en_col = 1'b1;
          else        en_key = 1'b1;
        end
        StDout:  en_dout = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: one instance per legal NR sharing
// the same stimulus; each test observes the instance it targets.
module tb_aes_round_sequencer;

  logic clock = 1'b0;
  logic reset_n, in_valid, mode, abort, out_ready;

  logic       ir[3], ov[3], bz[3], mq[3], il[3];
  logic       ei[3], es[3], er[3], ec[3], ek[3], ed[3];
  logic [3:0] rd[3], ki[3];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_round_sequencer #(.NR(10 + 2 * g)) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (ir[g]),
      .mode     (mode),
      .abort    (abort),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .busy     (bz[g]),
      .mode_q   (mq[g]),
      .round    (rd[g]),
      .key_idx  (ki[g]),
      .is_last  (il[g]),
      .en_init  (ei[g]),
      .en_sub   (es[g]),
      .en_row   (er[g]),
      .en_col   (ec[g]),
      .en_key   (ek[g]),
      .en_dout  (ed[g])
    );
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    int   sel;
    int   nr;
    logic mode;
    int   exp_dout;
  } vec_t;

  vec_t vecs[4];

  // 0 none, 1 init+key, 2 sub, 3 row, 4 col, 5 key, 6 dout, 7 illegal combination
  function automatic int stage_code(int s);
    int cnt;
    cnt = int'(ei[s]) + int'(es[s]) + int'(er[s]) + int'(ec[s]) + int'(ek[s]) + int'(ed[s]);
    if (cnt == 0) return 0;
    if (cnt == 2 && ei[s] && ek[s]) return 1;
    if (cnt > 1 || ei[s]) return 7;
    if (es[s]) return 2;
    if (er[s]) return 3;
    if (ec[s]) return 4;
    if (ek[s]) return 5;
    return 6;
  endfunction

  function automatic int exp_code(int nr, logic m, int cyc);
    int r, p;
    if (cyc == 1) return 1;
    if (cyc == 4 * nr + 1) return 6;
    if (cyc > 4 * nr + 1) return 0;
    r = (cyc + 2) / 4;
    p = (cyc - 2) % 4;
    if (!m) begin
      case (p)
        0: return 2;
        1: return 3;
        2: return (r == nr) ? 5 : 4;
        default: return 5;
      endcase
    end else begin
      case (p)
        0: return 3;
        1: return 2;
        2: return 5;
        default: return 4;
      endcase
    end
  endfunction

  function automatic int exp_key(int nr, logic m, int cyc);
    int r;
    if (cyc == 1) return m ? nr : 0;
    r = (cyc + 2) / 4;
    return m ? nr - r : r;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    in_valid  = 1'b0;
    mode      = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #2;
    reset_n   = 1'b1;
  endtask

  task automatic start_block(input logic m);
    @(negedge clock);
    in_valid = 1'b1;
    mode     = m;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    mode     = ~m;  // must be ignored while busy
  endtask

  // Runs one block through the first HOLD cycle and checks the whole timeline.
  task automatic run_vec(input vec_t v, input string tag);
    int s, dout_c, ov_c, stage_err, key_err, ncol, nkey, nlast;
    s = v.sel;
    dout_c = -1; ov_c = -1; stage_err = 0; key_err = 0; ncol = 0; nkey = 0; nlast = 0;
    start_block(v.mode);
    for (int cyc = 1; cyc <= v.exp_dout + 1; cyc++) begin
      @(negedge clock);
      if (stage_code(s) != exp_code(v.nr, v.mode, cyc)) stage_err++;
      if (cyc <= 4 * v.nr) begin
        if (int'(ki[s]) != exp_key(v.nr, v.mode, cyc)) key_err++;
        if (il[s]) nlast++;
      end
      if (ed[s] && dout_c < 0) dout_c = cyc;
      if (ov[s] && ov_c < 0) ov_c = cyc;
      ncol += int'(ec[s]);
      nkey += int'(ek[s]);
    end
    chk($sformatf("%s_dout_cycle", tag), dout_c, v.exp_dout);
    chk($sformatf("%s_out_valid_cycle", tag), ov_c, v.exp_dout + 1);
    chk($sformatf("%s_stage_errors", tag), stage_err, 0);
    chk($sformatf("%s_key_idx_errors", tag), key_err, 0);
    chk($sformatf("%s_en_col_count", tag), ncol, v.nr - 1);
    chk($sformatf("%s_en_key_count", tag), nkey, v.nr + 1);
    chk($sformatf("%s_is_last_cycles", tag), nlast, 3);
    chk($sformatf("%s_hold_in_ready", tag), int'(ir[s]), 0);
    chk($sformatf("%s_hold_busy", tag), int'(bz[s]), 0);
    chk($sformatf("%s_mode_q", tag), int'(mq[s]), int'(v.mode));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int err, d;
    vecs[0] = '{sel: 0, nr: 10, mode: 1'b0, exp_dout: 41};
    vecs[1] = '{sel: 0, nr: 10, mode: 1'b1, exp_dout: 41};
    vecs[2] = '{sel: 2, nr: 14, mode: 1'b0, exp_dout: 57};
    vecs[3] = '{sel: 1, nr: 12, mode: 1'b1, exp_dout: 49};

    in_valid = 1'b0; mode = 1'b0; abort = 1'b0; out_ready = 1'b0; reset_n = 1'b0;
    #3;
    reset_n = 1'b1;

    // Reset state
    @(negedge clock);
    chk("reset_out_valid", int'(ov[0]), 0);
    chk("reset_busy", int'(bz[0]), 0);
    chk("reset_round", int'(rd[0]), 0);
    chk("reset_mode_q", int'(mq[0]), 0);
    chk("reset_enables", stage_code(0), 0);
    chk("reset_in_ready", int'(ir[0]), 1);

    // Table-driven single blocks
    for (int i = 0; i < 4; i++) begin
      do_reset();
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure, then back-to-back accept out of HOLD
    do_reset();
    run_vec(vecs[0], "bp");
    err = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (!ov[0] || ir[0]) err++;
    end
    chk("bp_hold_stable", err, 0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mode      = 1'b1;
    #1;
    chk("bp_in_ready", int'(ir[0]), 1);
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    @(negedge clock);
    chk("b2b_init_enables", stage_code(0), 1);
    chk("b2b_out_valid_drop", int'(ov[0]), 0);
    chk("b2b_key_idx", int'(ki[0]), 10);
    d = -1;
    for (int cyc = 2; cyc <= 42; cyc++) begin
      @(negedge clock);
      if (ed[0] && d < 0) d = cyc;
    end
    chk("b2b_dout_cycle", d, 41);

    // Abort during round 5, P2
    do_reset();
    start_block(1'b0);
    for (int cyc = 1; cyc <= 19; cyc++) @(negedge clock);
    chk("abort_round_before", int'(rd[0]), 5);
    chk("abort_stage_before", stage_code(0), 3);
    abort = 1'b1;
    #1;
    chk("abort_no_enables", stage_code(0), 0);
    @(posedge clock);
    #1;
    abort = 1'b0;
    @(negedge clock);
    chk("abort_busy_after", int'(bz[0]), 0);
    chk("abort_round_after", int'(rd[0]), 0);
    chk("abort_in_ready_after", int'(ir[0]), 1);
    err = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (ed[0] || bz[0] || ov[0]) err++;
    end
    chk("abort_quiet", err, 0);
    run_vec(vecs[0], "post_abort");

    // Abort wins over a simultaneous accept in HOLD
    out_ready = 1'b1;
    in_valid  = 1'b1;
    abort     = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    abort     = 1'b0;
    @(negedge clock);
    chk("abort_vs_accept_busy", int'(bz[0]), 0);
    chk("abort_vs_accept_enables", stage_code(0), 0);
    chk("abort_vs_accept_out_valid", int'(ov[0]), 0);

    // Asynchronous reset during round 3
    do_reset();
    start_block(1'b0);
    for (int cyc = 1; cyc <= 11; cyc++) @(negedge clock);
    chk("rst_mid_busy_before", int'(bz[0]), 1);
    #2;
    reset_n = 1'b0;
    #1;
    err = int'(ov[0]) + int'(bz[0]) + int'(mq[0]) + int'(il[0]) + int'(rd[0]) + int'(ki[0])
        + stage_code(0);
    chk("rst_mid_outputs_zero", err, 0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    #1;
    chk("rst_mid_in_ready", int'(ir[0]), 1);
    run_vec(vecs[1], "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
